// File: rtl/sign_pkg.sv
// Shared types and constants for the sign-identification frame controller.
package sign_pkg;

    localparam int SIGN_W    = 4;
    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_FLAG,
        ST_WAIT,
        ST_SAMPLE
    } frame_state_t;

endpackage

// File: rtl/sign_debouncer.sv
// Publishes a sign result only after it has been seen on STABLE_FRAMES
// consecutive sample strobes; pulses sign_valid whenever the published value changes.
module sign_debouncer
    import sign_pkg::*;
#(
    parameter int STABLE_FRAMES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [SIGN_W-1:0] sign_in,
    output logic [SIGN_W-1:0] sign_out,
    output logic              sign_valid
);

    localparam int MATCH_W = $clog2(STABLE_FRAMES + 1);

    logic [SIGN_W-1:0]  cand_q, cand_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [SIGN_W-1:0]  out_q, out_d;
    logic               valid_q, valid_d;

    always_comb begin
        cand_d  = cand_q;
        match_d = match_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (en) begin
            if (sign_in == cand_q) begin
                if (match_q != MATCH_W'(STABLE_FRAMES))
                    match_d = match_q + 1'b1;
            end else begin
                cand_d  = sign_in;
                match_d = MATCH_W'(1);
            end
            // Publish decision uses the updated history, so it lands on the same edge.
            if (match_d == MATCH_W'(STABLE_FRAMES) && cand_d != out_q) begin
                out_d   = cand_d;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q  <= '0;
            match_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            match_q <= match_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign sign_out   = out_q;
    assign sign_valid = valid_q;

endmodule

// File: rtl/sign_frame_controller.sv
// Frame sequencer: streams IMG_W x IMG_H pixels into the pipeline, waits for it to
// drain, pulses the end-of-frame flag and samples the debounced sign result.
module sign_frame_controller
    import sign_pkg::*;
#(
    parameter int IMG_W         = DEF_IMG_W,
    parameter int IMG_H         = DEF_IMG_H,
    parameter int SETTLE_CYCLES = 8,
    parameter int RESULT_CYCLES = 4,
    parameter int STABLE_FRAMES = 3,
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              mode_bg,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              pipe_en,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic              flag,
    output logic              bg_diff,
    input  logic [SIGN_W-1:0] sign_in,
    output logic [SIGN_W-1:0] sign_out,
    output logic              sign_valid,
    output logic              busy
);

    localparam int CNT_MAX = (SETTLE_CYCLES > RESULT_CYCLES) ? SETTLE_CYCLES : RESULT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    frame_state_t     state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bg_q, bg_d;
    logic             ready_q, ready_d;
    logic             flag_q, flag_d;
    logic             busy_q, busy_d;

    assign pipe_en = pix_valid & ready_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        bg_d    = bg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                    bg_d    = mode_bg;
                end
            end
            ST_STREAM: begin
                if (pipe_en) begin
                    if (col_q == COL_W'(IMG_W - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(IMG_H - 1)) begin
                            row_d   = '0;
                            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_FLAG;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_FLAG: begin
                cnt_d   = CNT_W'(RESULT_CYCLES - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_SAMPLE: begin
                if (continuous) begin
                    state_d = ST_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                    bg_d    = mode_bg;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they align with it.
        ready_d = (state_d == ST_STREAM);
        flag_d  = (state_d == ST_FLAG);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            bg_q    <= 1'b0;
            ready_q <= 1'b0;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            bg_q    <= bg_d;
            ready_q <= ready_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
        end
    end

    sign_debouncer #(
        .STABLE_FRAMES(STABLE_FRAMES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == ST_SAMPLE),
        .sign_in   (sign_in),
        .sign_out  (sign_out),
        .sign_valid(sign_valid)
    );

    assign pix_ready = ready_q;
    assign col       = col_q;
    assign row       = row_q;
    assign flag      = flag_q;
    assign bg_diff   = bg_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sign_frame_controller.sv
// Bench for sign_frame_controller: a pixel-count / cycles-since-last-pixel model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sign_frame_controller;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int S   = 3;
    localparam int R   = 2;
    localparam int STB = 3;
    localparam int N   = W * H;

    logic       clk = 1'b0;
    logic       rst, start, continuous, mode_bg, pix_valid;
    logic       pix_ready, pipe_en, flag, bg_diff, sign_valid, busy;
    logic [1:0] col;
    logic       row;
    logic [3:0] sign_in, sign_out;

    sign_frame_controller #(
        .IMG_W(W), .IMG_H(H), .SETTLE_CYCLES(S), .RESULT_CYCLES(R), .STABLE_FRAMES(STB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .mode_bg(mode_bg),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pipe_en(pipe_en), .col(col), .row(row),
        .flag(flag), .bg_diff(bg_diff), .sign_in(sign_in), .sign_out(sign_out),
        .sign_valid(sign_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
        end
    endtask

    // Behavioural model: frame progress is "pixels accepted" plus "cycles since the
    // last pixel"; the debounce is the length of the trailing run of equal samples.
    bit m_active = 0;
    int m_n = 0;
    int m_since = 0;
    bit m_bg = 0;
    int m_out = 0;
    bit m_valid = 0;
    int hist[$];

    int cyc = 0;
    int strobe_cnt = 0, flag_cnt = 0, valid_cnt = 0;
    int last_strobe_cyc = 0, flag_cyc = 0, valid_at_flag = -1;

    always @(negedge clk) begin
        bit e_ready, e_pipe, e_flag;
        int run;
        cyc++;
        e_ready = m_active && (m_n < N);
        e_pipe  = e_ready && pix_valid;
        e_flag  = m_active && (m_n == N) && (m_since == S + 1);
        chk("pix_ready", int'(pix_ready), int'(e_ready));
        chk("pipe_en", int'(pipe_en), int'(e_pipe));
        chk("busy", int'(busy), int'(m_active));
        chk("flag", int'(flag), int'(e_flag));
        chk("bg_diff", int'(bg_diff), int'(m_bg));
        chk("sign_out", int'(sign_out), m_out);
        chk("sign_valid", int'(sign_valid), int'(m_valid));
        if (e_pipe) begin
            chk("row", int'(row), m_n / W);
            chk("col", int'(col), m_n % W);
        end

        if (pipe_en) begin strobe_cnt++; last_strobe_cyc = cyc; end
        if (flag) begin flag_cnt++; flag_cyc = cyc; end
        if (sign_valid) begin valid_cnt++; valid_at_flag = flag_cnt; end

        // Advance the model to the state after the coming rising edge.
        if (rst) begin
            m_active = 0; m_n = 0; m_since = 0; m_bg = 0; m_out = 0; m_valid = 0;
            hist.delete();
        end else begin
            m_valid = 0;
            if (!m_active) begin
                if (start) begin m_active = 1; m_n = 0; m_bg = mode_bg; end
            end else if (m_n < N) begin
                if (pix_valid) begin
                    m_n++;
                    if (m_n == N) m_since = 1;
                end
            end else if (m_since == S + R + 2) begin
                hist.push_back(int'(sign_in));
                if (hist.size() > 16) void'(hist.pop_front());
                run = 0;
                for (int i = hist.size() - 1; i >= 0 && hist[i] == int'(sign_in); i--) run++;
                if (run >= STB && int'(sign_in) != m_out) begin
                    m_out = int'(sign_in);
                    m_valid = 1;
                end
                if (continuous) begin m_n = 0; m_bg = mode_bg; end
                else m_active = 0;
            end else begin
                m_since++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(2); rst = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin tick(1); k++; end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic clear_obs();
        strobe_cnt = 0; flag_cnt = 0; valid_cnt = 0; valid_at_flag = -1;
    endtask

    int seq[6] = '{5, 5, 5, 5, 7, 5};

    initial begin
        rst = 1'b1; start = 0; continuous = 0; mode_bg = 0; pix_valid = 0; sign_in = 0;
        tick(2);
        rst = 1'b0;
        chk("rst_ready", int'(pix_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sign_out", int'(sign_out), 0);
        chk("rst_rowcol", int'({row, col}), 0);

        // Basic frame
        clear_obs(); pix_valid = 1;
        pulse_start();
        wait_idle();
        chk("basic_strobes", strobe_cnt, 8);
        chk("basic_flags", flag_cnt, 1);
        chk("basic_flag_delay", flag_cyc - last_strobe_cyc, 4);

        // Backpressure
        clear_obs();
        pulse_start();
        for (int i = 0; i < 40 && busy; i++) begin pix_valid = ~pix_valid; tick(1); end
        pix_valid = 1;
        wait_idle();
        chk("bp_strobes", strobe_cnt, 8);
        chk("bp_flags", flag_cnt, 1);

        // Mode latch
        mode_bg = 1;
        pulse_start();
        tick(2); mode_bg = 0; tick(2);
        chk("mode_mid", int'(bg_diff), 1);
        wait_idle();
        chk("mode_after", int'(bg_diff), 1);
        pulse_start();
        chk("mode_next", int'(bg_diff), 0);
        wait_idle();

        // Ignored start
        clear_obs();
        pulse_start(); tick(2); pulse_start();
        wait_idle();
        chk("ign_strobes", strobe_cnt, 8);
        chk("ign_flags", flag_cnt, 1);

        // Reset mid-frame
        clear_obs(); mode_bg = 1;
        pulse_start();
        for (int k = 0; k < 50 && strobe_cnt < 5; k++) tick(1);
        chk("mid_reach5", strobe_cnt, 5);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("mid_busy", int'(busy), 0);
        chk("mid_ready", int'(pix_ready), 0);
        chk("mid_bg", int'(bg_diff), 0);
        chk("mid_rowcol", int'({row, col}), 0);
        tick(10);
        chk("mid_noflag", flag_cnt, 0);
        clear_obs(); mode_bg = 0;
        pulse_start();
        wait_idle();
        chk("mid_restart_strobes", strobe_cnt, 8);

        // Debounce across continuous frames
        do_reset(); clear_obs();
        continuous = 1; sign_in = 5;
        pulse_start();
        for (int f = 0; f < 6; f++) begin
            int k = 0;
            while (flag_cnt < f + 1 && k < 100) begin tick(1); k++; end
            chk("deb_flag_seen", int'(flag_cnt >= f + 1), 1);
            sign_in = 4'(seq[f]);
            if (f == 5) continuous = 0;
        end
        wait_idle();
        chk("deb_valid_cnt", valid_cnt, 1);
        chk("deb_valid_frame", valid_at_flag, 3);
        chk("deb_sign_out", int'(sign_out), 5);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            pix_valid  = ($urandom % 4) != 0;
            start      = ($urandom % 8) == 0;
            continuous = ($urandom % 3) == 0;
            mode_bg    = 1'($urandom);
            sign_in    = (($urandom % 3) == 0) ? 4'($urandom) : 4'h9;
            rst        = ($urandom % 500) == 0;
            tick(1);
        end
        rst = 0; start = 0; continuous = 0; pix_valid = 1;
        wait_idle();
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
